hash_scorer: RTL and testbench

Downstream consumer of the Skein-1024 hash engine. Takes the 1024-bit hash result word-serially as the engine writes its hash register, and computes the Hamming distance to a fixed 1024-bit target. Tracks the best (lowest) score and the nonce that produced it. Presents each new best to the host-reporting stage over a valid/ready handshake.

---
 rtl/skein_search_pkg.sv | 19 +
 rtl/popcount64.sv | 22 ++
 rtl/hash_scorer.sv | 108 ++++++++++
 tb/tb_hash_scorer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_search_pkg.sv
// Shared constants and types for the Skein-1024 search pipeline.
package skein_search_pkg;

    localparam int WORD_W     = 64;
    localparam int HASH_WORDS = 16;
    localparam int SCORE_W    = 11;
    localparam int NONCE_W    = 64;
    localparam int IDX_W      = 4;
    localparam int POP_W      = 7;

    localparam logic [SCORE_W-1:0] SCORE_INIT = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree.
module popcount64 (
    input  logic [63:0] data,
    output logic [6:0]  count
);

    logic [1:0] lvl1 [32];
    logic [2:0] lvl2 [16];
    logic [3:0] lvl3 [8];
    logic [4:0] lvl4 [4];
    logic [5:0] lvl5 [2];

    always_comb begin
        for (int i = 0; i < 32; i++) lvl1[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
        for (int i = 0; i < 16; i++) lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        for (int i = 0; i < 8;  i++) lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        for (int i = 0; i < 4;  i++) lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        for (int i = 0; i < 2;  i++) lvl5[i] = {1'b0, lvl4[2*i]} + {1'b0, lvl4[2*i+1]};
        count = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};
    end

endmodule

// File: rtl/hash_scorer.sv
// Scores each streamed 1024-bit hash by Hamming distance to a fixed target,
// tracks the best score/nonce and reports improvements over valid/ready.
module hash_scorer
    import skein_search_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hash_start_i,
    input  logic               hash_word_valid_i,
    input  logic [WORD_W-1:0]  hash_word_i,
    input  logic [NONCE_W-1:0] nonce_i,
    output logic [IDX_W-1:0]   target_idx_o,
    input  logic [WORD_W-1:0]  target_word_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               score_valid_o,
    output logic [SCORE_W-1:0] best_score_o,
    output logic [NONCE_W-1:0] best_nonce_o,
    output logic               best_update_o,
    output logic               report_valid_o,
    input  logic               report_ready_i,
    output logic [SCORE_W-1:0] report_score_o,
    output logic [NONCE_W-1:0] report_nonce_o,
    output logic               busy_o,
    output logic               drop_o
);

    state_t             state, state_next;
    logic [IDX_W-1:0]   word_cnt;
    logic [SCORE_W-1:0] acc, acc_sum;
    logic [NONCE_W-1:0] nonce_q;
    logic [POP_W-1:0]   pop;
    logic               start_word, accum_word, last_word, improve;

    assign start_word = hash_word_valid_i & hash_start_i;
    assign accum_word = (state == ACCUM) & hash_word_valid_i & ~hash_start_i;
    assign last_word  = accum_word & (word_cnt == IDX_W'(HASH_WORDS - 1));
    assign acc_sum    = acc + SCORE_W'(pop);

    // A restart word is word 0 of the new hash, so it must see target word 0.
    assign target_idx_o = (state == ACCUM && !start_word) ? word_cnt : '0;

    popcount64 u_popcount (
        .data  (hash_word_i ^ target_word_i),
        .count (pop)
    );

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_word) state_next = ACCUM;
            ACCUM:   if (last_word)  state_next = FINISH;
            FINISH:  state_next = start_word ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_o        = (state == ACCUM);
    assign drop_o        = busy_o & start_word;
    assign score_valid_o = (state == FINISH);
    assign improve       = score_valid_o & (acc < best_score_o);
    assign best_update_o = improve;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt <= '0;
            acc      <= '0;
            nonce_q  <= '0;
            score_o  <= '0;
        end else if (start_word) begin
            acc      <= SCORE_W'(pop);
            word_cnt <= IDX_W'(1);
            nonce_q  <= nonce_i;
        end else if (accum_word) begin
            acc      <= acc_sum;
            word_cnt <= word_cnt + IDX_W'(1);
            if (last_word) score_o <= acc_sum;
        end
    end

    // Ties never improve, so the earliest nonce reaching a score is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_score_o   <= SCORE_INIT;
            best_nonce_o   <= '0;
            report_score_o <= '0;
            report_nonce_o <= '0;
            report_valid_o <= 1'b0;
        end else begin
            if (improve) begin
                best_score_o   <= acc;
                best_nonce_o   <= nonce_q;
                report_score_o <= acc;
                report_nonce_o <= nonce_q;
                report_valid_o <= 1'b1;
            end else if (report_ready_i) begin
                report_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hash_scorer.sv
// Self-checking bench for hash_scorer: hash-level reference model plus directed hashes.
module tb_hash_scorer;
    import skein_search_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               hash_start_i = 1'b0;
    logic               hash_word_valid_i = 1'b0;
    logic [WORD_W-1:0]  hash_word_i = '0;
    logic [NONCE_W-1:0] nonce_i = '0;
    logic [IDX_W-1:0]   target_idx_o;
    logic [WORD_W-1:0]  target_word_i;
    logic [SCORE_W-1:0] score_o, best_score_o, report_score_o;
    logic [NONCE_W-1:0] best_nonce_o, report_nonce_o;
    logic               score_valid_o, best_update_o, report_valid_o, busy_o, drop_o;
    logic               report_ready_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_bu = 0;
    int n_sv = 0;
    int n_drop = 0;

    hash_scorer dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .hash_start_i      (hash_start_i),
        .hash_word_valid_i (hash_word_valid_i),
        .hash_word_i       (hash_word_i),
        .nonce_i           (nonce_i),
        .target_idx_o      (target_idx_o),
        .target_word_i     (target_word_i),
        .score_o           (score_o),
        .score_valid_o     (score_valid_o),
        .best_score_o      (best_score_o),
        .best_nonce_o      (best_nonce_o),
        .best_update_o     (best_update_o),
        .report_valid_o    (report_valid_o),
        .report_ready_i    (report_ready_i),
        .report_score_o    (report_score_o),
        .report_nonce_o    (report_nonce_o),
        .busy_o            (busy_o),
        .drop_o            (drop_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] tgt(input logic [3:0] idx);
        return 64'h9E37_79B9_7F4A_7C15 * ({60'd0, idx} + 64'd3);
    endfunction

    assign target_word_i = tgt(target_idx_o);

    function automatic logic [63:0] ones_rot(input int k, input int r);
        logic [63:0]  m;
        logic [127:0] d;
        m = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
        d = {m, m} << r;
        return d[127:64];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collects whole hashes, scores them with $countones.
    logic [63:0]        q[$];
    logic               m_collect = 1'b0;
    logic [63:0]        m_nonce = '0;
    logic               m_fin = 1'b0;
    logic [10:0]        m_fin_score = '0;
    logic [63:0]        m_fin_nonce = '0;
    logic [10:0]        m_score = '0;
    logic [10:0]        m_best = 11'h7FF;
    logic [63:0]        m_bnonce = '0;
    logic [10:0]        m_rscore = '0;
    logic [63:0]        m_rnonce = '0;
    logic               m_rvalid = 1'b0;
    int                 m_sum;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
            m_collect = 0; m_nonce = 0; m_fin = 0; m_fin_score = 0; m_fin_nonce = 0;
            m_score = 0; m_best = 11'h7FF; m_bnonce = 0;
            m_rscore = 0; m_rnonce = 0; m_rvalid = 0;
        end else begin
            if (m_rvalid && report_ready_i) m_rvalid = 0;
            if (m_fin && m_fin_score < m_best) begin
                m_best = m_fin_score; m_bnonce = m_fin_nonce;
                m_rscore = m_fin_score; m_rnonce = m_fin_nonce; m_rvalid = 1;
            end
            m_fin = 0;
            if (hash_word_valid_i) begin
                if (hash_start_i) begin
                    q.delete();
                    q.push_back(hash_word_i);
                    m_nonce = nonce_i;
                    m_collect = 1;
                end else if (m_collect) begin
                    q.push_back(hash_word_i);
                    if (q.size() == 16) begin
                        m_sum = 0;
                        for (int i = 0; i < 16; i++) m_sum += $countones(q[i] ^ tgt(4'(i)));
                        m_fin_score = 11'(m_sum);
                        m_fin_nonce = m_nonce;
                        m_score = 11'(m_sum);
                        m_fin = 1;
                        m_collect = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("score_o", score_o, m_score);
            check("score_valid_o", score_valid_o, m_fin);
            check("best_update_o", best_update_o, m_fin && (m_fin_score < m_best));
            check("best_score_o", best_score_o, m_best);
            check("best_nonce_o", best_nonce_o, m_bnonce);
            check("report_valid_o", report_valid_o, m_rvalid);
            check("report_score_o", report_score_o, m_rscore);
            check("report_nonce_o", report_nonce_o, m_rnonce);
            check("busy_o", busy_o, m_collect);
            check("drop_o", drop_o, m_collect && hash_start_i && hash_word_valid_i);
            check("target_idx_o", target_idx_o,
                  (m_collect && !(hash_start_i && hash_word_valid_i)) ? 64'(q.size()) : 64'd0);
            if (best_update_o) n_bu++;
            if (score_valid_o) n_sv++;
            if (drop_o) n_drop++;
        end
    end

    task automatic idle(input int n);
        hash_start_i = 0;
        hash_word_valid_i = 0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Sends the first nwords of a hash whose distance to the target is total.
    task automatic send_hash(input logic [63:0] n, input int total, input int nwords);
        int k;
        for (int i = 0; i < nwords; i++) begin
            k = total / 16 + ((i < total % 16) ? 1 : 0);
            hash_start_i = (i == 0);
            hash_word_valid_i = 1;
            hash_word_i = tgt(4'(i)) ^ ones_rot(k, (i * 5) % 64);
            nonce_i = (i == 0) ? n : {$urandom, $urandom};
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1;
        hash_start_i = 0;
        hash_word_valid_i = 0;
        report_ready_i = 0;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        n_bu = 0; n_sv = 0; n_drop = 0;
    endtask

    initial begin
        #1 rst_i = 1;
        #1;
        check("rst score_o", score_o, 0);
        check("rst best_score_o", best_score_o, 11'h7FF);
        check("rst best_nonce_o", best_nonce_o, 0);
        check("rst report_valid_o", report_valid_o, 0);
        check("rst busy_o", busy_o, 0);
        @(posedge clk_i);
        #1 rst_i = 0;

        // Hash identical to target
        send_hash(64'h5, 0, 16);
        check("t1 score_valid", score_valid_o, 1);
        check("t1 score", score_o, 0);
        check("t1 best_update", best_update_o, 1);
        idle(1);
        check("t1 best_score", best_score_o, 0);
        check("t1 report_score", report_score_o, 0);
        check("t1 report_nonce", report_nonce_o, 64'h5);
        check("t1 report_valid", report_valid_o, 1);

        // Complement then one bit per word, back to back
        do_reset();
        send_hash(64'h1, 1024, 16);
        check("t2 score 1024", score_o, 1024);
        send_hash(64'h2, 16, 16);
        check("t2 score 16", score_o, 16);
        idle(1);
        check("t2 best_score", best_score_o, 16);
        check("t2 best_nonce", best_nonce_o, 64'h2);
        check("t2 best_update count", n_bu, 2);

        // Tie keeps the earlier nonce
        do_reset();
        send_hash(64'hA, 100, 16);
        idle(1);
        send_hash(64'hB, 100, 16);
        check("t3 score", score_o, 100);
        check("t3 no best_update", best_update_o, 0);
        idle(1);
        check("t3 best_nonce", best_nonce_o, 64'hA);
        check("t3 best_score", best_score_o, 100);

        // Restart after word 7
        do_reset();
        send_hash(64'h7, 500, 8);
        send_hash(64'hC, 40, 16);
        check("t4 score", score_o, 40);
        idle(2);
        check("t4 drop count", n_drop, 1);
        check("t4 score_valid count", n_sv, 1);
        check("t4 best_nonce", best_nonce_o, 64'hC);

        // Report held pending, overwritten, then accepted
        do_reset();
        send_hash(64'h31, 300, 16);
        send_hash(64'h32, 200, 16);
        send_hash(64'h33, 50, 16);
        idle(1);
        check("t5 report_valid", report_valid_o, 1);
        check("t5 report_score", report_score_o, 50);
        check("t5 report_nonce", report_nonce_o, 64'h33);
        report_ready_i = 1;
        idle(1);
        check("t5 report cleared", report_valid_o, 0);
        report_ready_i = 0;
        send_hash(64'h41, 30, 16);
        send_hash(64'h42, 20, 16);
        report_ready_i = 1;
        idle(1);
        check("t5 coincide valid", report_valid_o, 1);
        check("t5 coincide score", report_score_o, 20);
        idle(1);
        check("t5 coincide cleared", report_valid_o, 0);
        report_ready_i = 0;

        // Reset during word 9
        do_reset();
        send_hash(64'h51, 60, 16);
        idle(1);
        send_hash(64'h52, 500, 9);
        hash_start_i = 0;
        hash_word_valid_i = 1;
        hash_word_i = tgt(4'd9);
        #2 rst_i = 1;
        #1;
        check("t6 rst best_score", best_score_o, 11'h7FF);
        check("t6 rst best_nonce", best_nonce_o, 0);
        check("t6 rst report_valid", report_valid_o, 0);
        check("t6 rst busy", busy_o, 0);
        check("t6 rst score", score_o, 0);
        hash_word_valid_i = 0;
        @(posedge clk_i);
        #1 rst_i = 0;
        send_hash(64'h53, 77, 16);
        check("t6 score", score_o, 77);
        check("t6 best_update", best_update_o, 1);
        idle(1);
        check("t6 best_score", best_score_o, 77);
        check("t6 best_nonce", best_nonce_o, 64'h53);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
